// File: rtl/oam_dma_sequencer.sv
// Sprite OAM DMA: on a CPU write to $4014, halts the CPU and copies page $XX00-$XXFF
// to the PPU OAM data port using alternating get/put CPU cycles.
module oam_dma_sequencer #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ph2_rising,
    input  logic        ph2_falling,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rnw,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic [15:0] dma_addr,
    output logic        dma_rnw,
    output logic [7:0]  dma_dout,
    output logic        dma_done
);

    // state  | meaning
    // IDLE   | CPU owns the bus, waiting for a $4014 write
    // HALT   | CPU halted, dummy read of {page,idx}
    // ALIGN  | extra dummy read so the first READ lands on an even (get) cycle
    // READ   | read {page,idx}, capture data at end of cycle
    // WRITE  | write captured byte to OAM data port
    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state, state_nxt;
    logic        cycle_odd;
    logic [7:0]  page, page_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [7:0]  data_buf, data_buf_nxt;
    logic        done_nxt;
    logic        cpu_rdy_nxt;
    logic        dma_busy_nxt;
    logic [15:0] dma_addr_nxt;
    logic        dma_rnw_nxt;
    logic [7:0]  dma_dout_nxt;

    // The CPU cycle start strobe carries no information this block needs.
    logic unused_inputs;
    assign unused_inputs = ph2_rising;

    always_comb begin
        state_nxt    = state;
        page_nxt     = page;
        idx_nxt      = idx;
        data_buf_nxt = data_buf;
        done_nxt     = 1'b0;
        if (ph2_falling) begin
            case (state)
                S_IDLE: begin
                    if (!cpu_rnw && cpu_addr == DMA_REG_ADDR) begin
                        page_nxt  = cpu_data_in;
                        idx_nxt   = 8'h00;
                        state_nxt = S_HALT;
                    end
                end
                S_HALT:  state_nxt = cycle_odd ? S_READ : S_ALIGN;
                S_ALIGN: state_nxt = S_READ;
                S_READ: begin
                    data_buf_nxt = mem_rdata;
                    state_nxt    = S_WRITE;
                end
                S_WRITE: begin
                    if (idx == 8'hFF) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt   = idx + 8'd1;
                        state_nxt = S_READ;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        // Outputs are decoded from the state being entered so they are registered
        // on the same edge and stay stable for the whole following CPU cycle.
        cpu_rdy_nxt  = 1'b1;
        dma_busy_nxt = 1'b0;
        dma_addr_nxt = 16'h0000;
        dma_rnw_nxt  = 1'b1;
        dma_dout_nxt = 8'h00;
        case (state_nxt)
            S_HALT, S_ALIGN, S_READ: begin
                cpu_rdy_nxt  = 1'b0;
                dma_busy_nxt = 1'b1;
                dma_addr_nxt = {page_nxt, idx_nxt};
            end
            S_WRITE: begin
                cpu_rdy_nxt  = 1'b0;
                dma_busy_nxt = 1'b1;
                dma_addr_nxt = OAM_DATA_ADDR;
                dma_rnw_nxt  = 1'b0;
                dma_dout_nxt = data_buf_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cycle_odd <= 1'b0;
            page      <= 8'h00;
            idx       <= 8'h00;
            data_buf  <= 8'h00;
            cpu_rdy   <= 1'b1;
            dma_busy  <= 1'b0;
            dma_addr  <= 16'h0000;
            dma_rnw   <= 1'b1;
            dma_dout  <= 8'h00;
            dma_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cycle_odd <= cycle_odd ^ ph2_falling;
            page      <= page_nxt;
            idx       <= idx_nxt;
            data_buf  <= data_buf_nxt;
            cpu_rdy   <= cpu_rdy_nxt;
            dma_busy  <= dma_busy_nxt;
            dma_addr  <= dma_addr_nxt;
            dma_rnw   <= dma_rnw_nxt;
            dma_dout  <= dma_dout_nxt;
            dma_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_oam_dma_sequencer.sv
// Randomized bench for oam_dma_sequencer: a CPU-cycle level model predicts the bus
// activity of every cycle of each transfer from the page, alignment and memory image.
module tb_oam_dma_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ph2_rising;
    logic        ph2_falling;
    logic [15:0] cpu_addr;
    logic        cpu_rnw;
    logic [7:0]  cpu_data_in;
    logic [7:0]  mem_rdata;
    logic        cpu_rdy;
    logic        dma_busy;
    logic [15:0] dma_addr;
    logic        dma_rnw;
    logic [7:0]  dma_dout;
    logic        dma_done;

    oam_dma_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ph2_rising  (ph2_rising),
        .ph2_falling (ph2_falling),
        .cpu_addr    (cpu_addr),
        .cpu_rnw     (cpu_rnw),
        .cpu_data_in (cpu_data_in),
        .mem_rdata   (mem_rdata),
        .cpu_rdy     (cpu_rdy),
        .dma_busy    (dma_busy),
        .dma_addr    (dma_addr),
        .dma_rnw     (dma_rnw),
        .dma_dout    (dma_dout),
        .dma_done    (dma_done)
    );

    always #5 clk = ~clk;

    // Memory manager: registered read data is held for the whole cycle, so a
    // combinational lookup of the stable bus address is equivalent here.
    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[dma_addr];

    typedef struct {
        logic [15:0] addr;
        logic        rnw;
        logic [7:0]  dout;
    } bus_t;

    bus_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   par_m    = 1'b0;

    logic        s_busy, s_rdy, s_rnw, s_done1, s_done2;
    logic [15:0] s_addr;
    logic [7:0]  s_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One CPU cycle of four clks; samples outputs just after the commit edge and
    // again one clk later to see the width of dma_done.
    task automatic cpu_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d);
        cpu_addr    = a;
        cpu_rnw     = rnw;
        cpu_data_in = d;
        ph2_rising  = 1'b1;
        @(negedge clk);
        ph2_rising  = 1'b0;
        @(negedge clk);
        ph2_falling = 1'b1;
        @(negedge clk);
        ph2_falling = 1'b0;
        par_m       = ~par_m;
        s_busy  = dma_busy;
        s_rdy   = cpu_rdy;
        s_addr  = dma_addr;
        s_rnw   = dma_rnw;
        s_dout  = dma_dout;
        s_done1 = dma_done;
        @(negedge clk);
        s_done2 = dma_done;
    endtask

    // Halted-CPU cycle; occasionally a forced $4014 write that must be ignored.
    task automatic junk_cycle();
        if ($urandom_range(3) == 0) cpu_cycle(16'h4014, 1'b0, 8'($urandom));
        else cpu_cycle(16'($urandom), 1'($urandom), 8'($urandom));
    endtask

    task automatic idle_cycle();
        cpu_cycle(16'h0000, 1'b1, 8'h00);
        check("idle_busy", 32'(s_busy), 0);
        check("idle_rdy", 32'(s_rdy), 1);
    endtask

    task automatic run_transfer(input logic [7:0] pg, input int abort_after);
        bit          halt_odd;
        int          exp_len;
        int          busy_cnt;
        logic [15:0] a;
        exp_q.delete();
        halt_odd = ~par_m;
        exp_len  = halt_odd ? 513 : 514;
        exp_q.push_back('{addr: {pg, 8'h00}, rnw: 1'b1, dout: 8'h00});
        if (!halt_odd) exp_q.push_back('{addr: {pg, 8'h00}, rnw: 1'b1, dout: 8'h00});
        for (int i = 0; i < 256; i++) begin
            a = {pg, 8'(i)};
            exp_q.push_back('{addr: a, rnw: 1'b1, dout: 8'h00});
            exp_q.push_back('{addr: 16'h2004, rnw: 1'b0, dout: mem[a]});
        end
        busy_cnt = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 0) cpu_cycle(16'h4014, 1'b0, pg);
            else junk_cycle();
            if (s_busy) busy_cnt++;
            check("busy", 32'(s_busy), 1);
            check("rdy", 32'(s_rdy), 0);
            check("addr", 32'(s_addr), 32'(exp_q[k].addr));
            check("rnw", 32'(s_rnw), 32'(exp_q[k].rnw));
            if (!exp_q[k].rnw) check("dout", 32'(s_dout), 32'(exp_q[k].dout));
            check("done_early", 32'(s_done1), 0);
            if (abort_after != 0 && k == abort_after) return;
        end
        junk_cycle();
        check("done_pulse", 32'(s_done1), 1);
        check("done_width", 32'(s_done2), 0);
        check("end_busy", 32'(s_busy), 0);
        check("end_rdy", 32'(s_rdy), 1);
        check("length", 32'(busy_cnt), 32'(exp_len));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdy"}, 32'(cpu_rdy), 1);
        check({tag, "_busy"}, 32'(dma_busy), 0);
        check({tag, "_addr"}, 32'(dma_addr), 0);
        check({tag, "_rnw"}, 32'(dma_rnw), 1);
        check({tag, "_dout"}, 32'(dma_dout), 0);
        check({tag, "_done"}, 32'(dma_done), 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'h5A;

        rst_n       = 1'b0;
        ph2_rising  = 1'b0;
        ph2_falling = 1'b0;
        cpu_addr    = 16'h0000;
        cpu_rnw     = 1'b1;
        cpu_data_in = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        par_m = 1'b0;
        @(negedge clk);

        // Writes elsewhere and reads of $4014 must not start a transfer.
        cpu_cycle(16'h4015, 1'b0, 8'h02);
        check("nt4015_busy", 32'(s_busy), 0);
        check("nt4015_rdy", 32'(s_rdy), 1);
        cpu_cycle(16'h2004, 1'b0, 8'h02);
        check("nt2004_busy", 32'(s_busy), 0);
        check("nt2004_rdy", 32'(s_rdy), 1);
        cpu_cycle(16'h4014, 1'b1, 8'h02);
        check("nt4014r_busy", 32'(s_busy), 0);
        check("nt4014r_rdy", 32'(s_rdy), 1);
        check("nt_done", 32'(s_done1), 0);

        // HALT lands on an odd cycle: no ALIGN.
        if (par_m) idle_cycle();
        run_transfer(8'h02, 0);
        // HALT lands on an even cycle: one ALIGN.
        if (!par_m) idle_cycle();
        run_transfer(8'h02, 0);

        idle_cycle();
        run_transfer(8'h03, 0);
        idle_cycle();
        run_transfer(8'hFF, 0);
        // Trigger on the first cycle after dma_done.
        run_transfer(8'($urandom), 0);

        // Reset mid-transfer, then a fresh transfer must restart from idx 0.
        idle_cycle();
        run_transfer(8'h05, 200);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        par_m = 1'b0;
        @(negedge clk);
        idle_cycle();
        run_transfer(8'h05, 0);

        for (int t = 0; t < 3; t++) begin
            repeat ($urandom_range(3)) idle_cycle();
            run_transfer(8'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
